// File: rtl/two_dir_fir_pkg.sv
// Shared types and Q12 arithmetic for the separable 3x3 FIR filter.
// fir3_round_sat is reused by both the vertical and horizontal stages.
package two_dir_fir_pkg;

    localparam int PIX_W     = 8;
    localparam int COEF_W    = 14;
    localparam int FRAC_BITS = 12;
    localparam int ROUND     = 1 << (FRAC_BITS - 1);
    localparam int PROD_W    = PIX_W + COEF_W + 1;
    localparam int ACC_W     = PROD_W + 2;

    typedef logic        [PIX_W-1:0]  pix_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_e;

    function automatic pix_t fir3_round_sat(
        input pix_t  p0,
        input pix_t  p1,
        input pix_t  p2,
        input coef_t c0,
        input coef_t c1,
        input coef_t c2
    );
        logic signed [PROD_W-1:0] a0, a1, a2;
        logic signed [PROD_W-1:0] k0, k1, k2;
        acc_t acc;
        acc_t sh;
        pix_t res;
        a0 = {{(PROD_W-PIX_W){1'b0}}, p0};
        a1 = {{(PROD_W-PIX_W){1'b0}}, p1};
        a2 = {{(PROD_W-PIX_W){1'b0}}, p2};
        k0 = {{(PROD_W-COEF_W){c0[COEF_W-1]}}, c0};
        k1 = {{(PROD_W-COEF_W){c1[COEF_W-1]}}, c1};
        k2 = {{(PROD_W-COEF_W){c2[COEF_W-1]}}, c2};
        acc = acc_t'(a0 * k0) + acc_t'(a1 * k1) + acc_t'(a2 * k2)
            + acc_t'(ROUND);
        sh = acc >>> FRAC_BITS;
        if (sh[ACC_W-1])
            res = '0;
        else if (|sh[ACC_W-2:PIX_W])
            res = '1;
        else
            res = sh[PIX_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/two_dir_fir_if.sv
// Pixel stream bundle: input strobe/ready/data and output strobe/data.
// Names are from the filter's point of view.
interface two_dir_fir_if #(
    parameter int DW = 8
);
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic          valid_o;
    logic [DW-1:0] data_o;

    modport master (
        output valid_i, data_i,
        input  ready_o, valid_o, data_o
    );

    modport slave (
        input  valid_i, data_i,
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/two_dir_fir_filter_line_buffer.sv
// One row of pixel storage: one write port, one asynchronous read port.
// Not reset; every location is written before it is read within a frame.
module line_buffer #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/two_dir_fir_filter.sv
// Separable 3x3 FIR: vertical taps over two line buffers, then horizontal
// taps, with edge replication and an H-cycle flush for the bottom row.
module two_dir_fir_filter
    import two_dir_fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int TAP_NUMS    = 3,
    parameter int COEFF_WIDTH = 14,
    parameter int PIXEL_NUM   = 1024,
    parameter int REPEAT_NUN  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ce_i,
    two_dir_fir_if.slave                  pix,
    input  logic signed [COEFF_WIDTH-1:0] coeff00_v_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff10_v_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff20_v_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff00_h_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff01_h_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff02_h_i,
    input  logic [11:0]                   h_size_i,
    input  logic [11:0]                   v_size_i
);
    localparam int LOG_N = $clog2(PIXEL_NUM);
    localparam int CNT_W = (LOG_N > ADDR_WIDTH) ? ADDR_WIDTH : LOG_N;

    if (TAP_NUMS != 3 || REPEAT_NUN != TAP_NUMS - 1 ||
        DATA_WIDTH != PIX_W || COEFF_WIDTH != COEF_W) begin : g_bad_cfg
        $error("two_dir_fir_filter: unsupported parameter set");
    end

    typedef logic [CNT_W-1:0] cnt_t;

    state_e state_q, state_d;
    cnt_t   col_q, col_d, row_q, row_d;
    cnt_t   hl_q, hl_d, vl_q, vl_d;
    cnt_t   hl, vl;
    logic   ready, acc, vs, flush;
    pix_t   lb0_rd, lb1_rd, vp0, vp2, v_res;

    logic v_vld_q, v_first_q, v_last_q, pend_q;
    logic h_vld_q, o_vld_q, h_fire;
    pix_t v_dat_q, sm1_q, s0_q, h_dat_q, o_dat_q, h_p2, h_res;

    // Frame size is live while idle so the first pixel sees it.
    assign hl    = (state_q == IDLE) ? cnt_t'(h_size_i - 12'd1) : hl_q;
    assign vl    = (state_q == IDLE) ? cnt_t'(v_size_i - 12'd1) : vl_q;
    assign flush = (state_q == FLUSH);
    assign ready = ce_i && !flush;
    assign acc   = ready && pix.valid_i;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        hl_d    = hl;
        vl_d    = vl;
        vs      = 1'b0;
        unique case (state_q)
            IDLE, STREAM: begin
                if (acc) begin
                    state_d = STREAM;
                    vs      = (row_q != '0);
                    if (col_q == hl) begin
                        col_d = '0;
                        if (row_q == vl) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + cnt_t'(1);
                        end
                    end else begin
                        col_d = col_q + cnt_t'(1);
                    end
                end
            end
            FLUSH: begin
                if (ce_i) begin
                    vs = 1'b1;
                    if (col_q == hl) begin
                        col_d   = '0;
                        state_d = IDLE;
                    end else begin
                        col_d = col_q + cnt_t'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    line_buffer #(.DEPTH(PIXEL_NUM), .AW(CNT_W), .W(PIX_W)) u_lb0 (
        .clk     (clk),
        .we_i    (acc),
        .waddr_i (col_q),
        .wdata_i (lb1_rd),
        .raddr_i (col_q),
        .rdata_o (lb0_rd)
    );

    line_buffer #(.DEPTH(PIXEL_NUM), .AW(CNT_W), .W(PIX_W)) u_lb1 (
        .clk     (clk),
        .we_i    (acc),
        .waddr_i (col_q),
        .wdata_i (pix.data_i),
        .raddr_i (col_q),
        .rdata_o (lb1_rd)
    );

    // Row -1 mirrors row 0; during flush row V mirrors row V-1.
    assign vp0   = (!flush && row_q == cnt_t'(1)) ? lb1_rd : lb0_rd;
    assign vp2   = flush ? lb1_rd : pix.data_i;
    assign v_res = fir3_round_sat(vp0, lb1_rd, vp2,
                                  coeff00_v_i, coeff10_v_i, coeff20_v_i);

    assign h_fire = (v_vld_q && !v_first_q) || pend_q;
    assign h_p2   = pend_q ? s0_q : v_dat_q;
    assign h_res  = fir3_round_sat(sm1_q, s0_q, h_p2,
                                   coeff00_h_i, coeff01_h_i, coeff02_h_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            hl_q      <= '0;
            vl_q      <= '0;
            v_vld_q   <= 1'b0;
            v_first_q <= 1'b0;
            v_last_q  <= 1'b0;
            v_dat_q   <= '0;
            sm1_q     <= '0;
            s0_q      <= '0;
            pend_q    <= 1'b0;
            h_vld_q   <= 1'b0;
            h_dat_q   <= '0;
            o_vld_q   <= 1'b0;
            o_dat_q   <= '0;
        end else if (ce_i) begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            hl_q      <= hl_d;
            vl_q      <= vl_d;
            v_vld_q   <= vs;
            v_first_q <= (col_q == '0);
            v_last_q  <= (col_q == hl);
            v_dat_q   <= v_res;
            if (v_vld_q) begin
                s0_q  <= v_dat_q;
                sm1_q <= v_first_q ? v_dat_q : s0_q;
            end
            pend_q  <= v_vld_q && v_last_q;
            h_vld_q <= h_fire;
            h_dat_q <= h_res;
            o_vld_q <= h_vld_q;
            if (h_vld_q)
                o_dat_q <= h_dat_q;
        end
    end

    assign pix.ready_o = ready;
    assign pix.valid_o = o_vld_q && ce_i;
    assign pix.data_o  = o_dat_q;
endmodule

// File: tb/tb_two_dir_fir_filter.sv
// Scoreboard bench for two_dir_fir_filter: a direct 2-D clamp-index model
// fills an expected queue; the output monitor pops and compares.
module tb_two_dir_fir_filter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_i;
    logic [11:0] h_size, v_size;
    int          kv[3];
    int          kh[3];

    two_dir_fir_if #(.DW(8)) bus ();

    two_dir_fir_filter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce_i        (ce_i),
        .pix         (bus),
        .coeff00_v_i (14'(kv[0])),
        .coeff10_v_i (14'(kv[1])),
        .coeff20_v_i (14'(kv[2])),
        .coeff00_h_i (14'(kh[0])),
        .coeff01_h_i (14'(kh[1])),
        .coeff02_h_i (14'(kh[2])),
        .h_size_i    (h_size),
        .v_size_i    (v_size)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int q[$];
    int img[0:4095];
    int got[0:4095];
    int ref_out[0:4095];
    int got_n = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rs(input int a, input int b, input int c,
                              input int k0, input int k1, input int k2);
        int s;
        s = (a * k0 + b * k1 + c * k2 + 2048) >>> 12;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int cl(input int i, input int n);
        if (i < 0) return 0;
        if (i >= n) return n - 1;
        return i;
    endfunction

    task automatic model(input int h, input int v);
        int vt[0:4095];
        for (int r = 0; r < v; r++)
            for (int c = 0; c < h; c++)
                vt[r*h+c] = rs(img[cl(r-1, v)*h+c], img[r*h+c],
                               img[cl(r+1, v)*h+c], kv[0], kv[1], kv[2]);
        for (int r = 0; r < v; r++)
            for (int c = 0; c < h; c++)
                q.push_back(rs(vt[r*h+cl(c-1, h)], vt[r*h+c],
                               vt[r*h+cl(c+1, h)], kh[0], kh[1], kh[2]));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.valid_o) begin
            if (q.size() == 0) begin
                chk("unexpected_out", int'(bus.valid_o), 0);
            end else begin
                chk("pix", int'(bus.data_o), q.pop_front());
                if (got_n < 4096) got[got_n] = int'(bus.data_o);
                got_n++;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic run_frame(input int h, input int v, input bit tog,
                             input int abort_at);
        int idx = 0;
        int cyc = 0;
        int guard = 0;
        int lowc = 0;
        got_n = 0;
        model(h, v);
        h_size = 12'(h);
        v_size = 12'(v);
        while (idx < h * v && guard < 20000) begin
            if (idx == abort_at) begin
                ce_i = 1'b1;
                bus.valid_i = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                chk("rst_valid_o", int'(bus.valid_o), 0);
                chk("rst_ready_o", int'(bus.ready_o), 1);
                q.delete();
                rst_n = 1'b1;
                return;
            end
            ce_i = tog ? ((cyc / 7) % 2 == 0) : 1'b1;
            bus.valid_i = 1'b1;
            bus.data_i = 8'(img[idx]);
            @(negedge clk);
            if (ce_i && bus.ready_o) idx++;
            @(posedge clk); #1;
            cyc++;
            guard++;
        end
        chk("frame_accepted", idx, h * v);
        bus.valid_i = 1'b0;
        guard = 0;
        while (guard < 5000) begin
            ce_i = tog ? ((cyc / 7) % 2 == 0) : 1'b1;
            @(negedge clk);
            if (ce_i && bus.ready_o) break;
            if (ce_i) lowc++;
            @(posedge clk); #1;
            cyc++;
            guard++;
        end
        @(posedge clk); #1;
        chk("flush_len", lowc, h);
        ce_i = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);
        chk("out_count", got_n, h * v);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ce_i = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i = '0;
        h_size = 12'd4;
        v_size = 12'd4;
        kv = '{1024, 2048, 1024};
        kh = '{1024, 2048, 1024};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid_o", int'(bus.valid_o), 0);
        chk("reset_data_o", int'(bus.data_o), 0);
        chk("reset_ready_o", int'(bus.ready_o), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) img[i] = i + 1;
        run_frame(4, 4, 1'b0, -1);
        chk("ramp_00", got[0], 2);
        chk("ramp_11", got[5], 6);
        chk("ramp_33", got[15], 15);

        for (int i = 0; i < 64; i++) img[i] = 0;
        img[3*8+3] = 64;
        run_frame(8, 8, 1'b0, -1);
        chk("imp_33", got[3*8+3], 16);
        chk("imp_23", got[2*8+3], 8);
        chk("imp_22", got[2*8+2], 4);
        chk("imp_11", got[1*8+1], 0);
        chk("imp_55", got[5*8+5], 0);

        for (int i = 0; i < 4096; i++) img[i] = 100;
        run_frame(64, 64, 1'b0, -1);
        chk("flat_last", got[4095], 100);

        kv = '{-512, 3072, 1536};
        kh = '{1536, 2560, -256};
        for (int i = 0; i < 4096; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(64, 64, 1'b0, -1);
        for (int i = 0; i < 4096; i++) ref_out[i] = got[i];
        run_frame(64, 64, 1'b1, -1);
        begin
            int mism = 0;
            for (int i = 0; i < 4096; i++)
                if (got[i] != ref_out[i]) mism++;
            chk("ce_seq_mismatches", mism, 0);
        end

        kv = '{2048, 2048, 2048};
        kh = '{2048, 2048, 2048};
        for (int i = 0; i < 16; i++) img[i] = 255;
        run_frame(4, 4, 1'b0, -1);
        chk("sat_hi", got[6], 255);
        kv = '{2048, 12288 - 16384, 2048};
        kh = '{2048, 12288 - 16384, 2048};
        run_frame(4, 4, 1'b0, -1);
        chk("sat_lo", got[6], 0);

        kv = '{1024, 2048, 1024};
        kh = '{-512, 5120, -512};
        for (int i = 0; i < 4096; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(64, 64, 1'b0, 1000);
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", int'(bus.valid_o), 0);
        for (int i = 0; i < 48; i++) img[i] = int'($urandom_range(0, 255));
        run_frame(8, 6, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/two_dir_fir_filter.md
# two_dir_fir_filter

Separable 2-D 3×3 FIR filter for a raster pixel stream: a 3-tap vertical FIR over two line buffers, then a 3-tap horizontal FIR. Frame edges use edge-pixel replication. It sits in the video pipeline between a pixel source and a downstream consumer, one pixel in and one pixel out per enabled cycle. The module is named `two_dir_fir_filter`.

## Interface
- DATA_WIDTH, 8: pixel width, unsigned.
- ADDR_WIDTH, 32: internal address/counter width ceiling; counters use `$clog2(PIXEL_NUM)` bits, capped at ADDR_WIDTH.
- TAP_NUMS, 3: taps per direction; only 3 is supported (elaboration error otherwise).
- COEFF_WIDTH, 14: coefficient width, signed Q(COEFF_WIDTH-12).12 (0x1000 = 1.0).
- PIXEL_NUM, 1024: line-buffer depth, the maximum h_size_i.
- REPEAT_NUN, 2: replicated border pixels per frame edge; must equal TAP_NUMS-1 (that is, 1 per side).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous, active-low.
- ce_i  in  1  clock enable; when 0, all state freezes.
- valid_i  in  1  input pixel strobe.
- ready_o  out  1  accept indication.
- data_i  in  DATA_WIDTH  input pixel, raster order.
- coeff00_v_i, coeff10_v_i, coeff20_v_i  in  COEFF_WIDTH  vertical taps for rows r-1, r, r+1.
- coeff00_h_i, coeff01_h_i, coeff02_h_i  in  COEFF_WIDTH  horizontal taps for cols c-1, c, c+1.
- h_size_i, v_size_i  in  12  frame width and height; range 2..PIXEL_NUM; sampled at frame start.
- valid_o  out  1  output pixel strobe.
- data_o  out  DATA_WIDTH  filtered pixel.

## Operation
- A pixel is accepted when `ce_i && valid_i && ready_o`. Row and column counters advance per accepted pixel; a frame is exactly h×v pixels, and the next frame starts immediately after.
- Vertical stage:
  - Two line buffers, each PIXEL_NUM deep, hold rows r-1 and r.
  - The vertical result for (r,c) is produced when pixel (r+1,c) is accepted.
  - Row -1 replicates row 0. Row V is replicated from row V-1.
- End-of-frame flush: after the last pixel of a frame is accepted, ready_o=0 for H enabled cycles. During these cycles the block internally generates the bottom row's vertical results, then ready_o returns to 1.
- Horizontal stage:
  - Output (r,c) is emitted when vertical sample c+1 of row r arrives.
  - Output (r,H-1) is emitted on the next enabled cycle after vertical sample H-1, using col H = col H-1.
  - Col -1 = col 0.
- Arithmetic, per stage:
  - Signed products, width DATA_WIDTH+COEFF_WIDTH+1, summed with 2 guard bits.
  - Round by adding 2^11, arithmetic shift right 12.
  - Saturate to [0, 2^DATA_WIDTH-1].
  - The vertical result is rounded and saturated before entering the horizontal stage.
- Exactly H×V outputs per frame, in raster order.

## Timing
- Reset (rst_n=0 at posedge): valid_o=0, data_o=0, ready_o=1, counters=0, flush cleared. Line-buffer contents are don't-care (never read before being written within a frame).
- Reset mid-frame aborts the frame; the next accepted pixel is (0,0).
- ce_i=0: no state change, valid_o=0, ready_o=0 combinationally, data_o holds.
- Latency:
  - Registered output; valid_o rises 3 enabled cycles after the triggering event (the vertical sample arrival defined above).
  - Continuous input streams produce continuous output within rows. The row-end output fills the slot vacated by col 0 of the next row.
- valid_i with ready_o=0 is ignored; the pixel is not captured.
- h_size_i and v_size_i changes take effect only at frame start.

## Structure
- Shared package `two_dir_fir_pkg`:
  - Q12 constants FRAC_BITS=12 and ROUND=2^11.
  - Typedefs for the pixel, the coefficient and the accumulator.
  - Function `fir3_round_sat(p0,p1,p2,c0,c1,c2)`.
- Sub-module `line_buffer`: single-port-per-side RAM, depth PIXEL_NUM, instantiated twice. The top level holds counters, flush FSM (IDLE/STREAM/FLUSH), and both FIR stages.

## Test plan
- Flat field: H=V=64, coeffs 0x400/0x800/0x400 both directions, all pixels 100 → 4096 outputs, all 100.
- Small ramp: H=V=4, inputs 1..16 raster → out(0,0)=2, out(1,1)=6, out(3,3)=15, 16 outputs total.
- Impulse: H=V=8, zero frame with 64 at (3,3) → out(3,3)=16, out(2,3)=8, out(2,2)=4, and 0 outside the 3×3 neighbourhood.
- Saturation: all pixels 255, coeffs 0x800 ×3 → data_o=255. With negative coeff 0xF000 on the centre tap → data_o=0.
- Flow control: stream 64×64 with ce_i toggled every 7 cycles → identical output sequence to the ce_i=1 run. ready_o=0 for exactly 64 enabled cycles after the last pixel.
- Reset mid-frame: assert rst_n=0 at pixel 1000, then send a fresh frame → valid_o=0 at reset, and the full correct frame follows.
